// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared tile codes, colours, FSM states and the built-in level map
package maze_pkg;

  typedef enum logic [3:0] {
    T_EMPTY  = 4'd0,
    T_UP     = 4'd1,
    T_RIGHT  = 4'd2,
    T_DOWN   = 4'd3,
    T_LEFT   = 4'd4,
    T_UL     = 4'd5,
    T_UR     = 4'd6,
    T_LR     = 4'd7,
    T_LL     = 4'd8,
    T_PELLET = 4'd9,
    T_POWER  = 4'd10,
    T_DOOR   = 4'd11,
    T_RSV12  = 4'd12,
    T_RSV13  = 4'd13,
    T_RSV14  = 4'd14,
    T_RSV15  = 4'd15
  } tile_code_t;

  typedef enum logic [1:0] {ST_RELOAD, ST_IDLE, ST_RD, ST_CHK} state_t;

  localparam logic [11:0] COL_BLACK  = 12'h000;
  localparam logic [11:0] COL_WALL   = 12'h00F;
  localparam logic [11:0] COL_PELLET = 12'hFBA;
  localparam logic [11:0] COL_DOOR   = 12'hFBF;

  function automatic logic is_edible(tile_code_t c);
    return (c == T_PELLET) || (c == T_POWER);
  endfunction

  // Level ROM: framed box, pellets on odd rows except the middle one, four power
  // pellets, a two-tile door on row 12 and the reserved codes on row 2.
  function automatic tile_code_t rom_tile(int col, int row, int w, int h);
    if (row == 0)     return (col == 0) ? T_UL : (col == w - 1) ? T_UR : T_UP;
    if (row == h - 1) return (col == 0) ? T_LL : (col == w - 1) ? T_LR : T_DOWN;
    if (col == 0)     return T_LEFT;
    if (col == w - 1) return T_RIGHT;
    if ((row == 1 || row == h - 2) && (col == 1 || col == w - 2)) return T_POWER;
    if (row == 12 && (col == w / 2 - 1 || col == w / 2)) return T_DOOR;
    if (row == 2 && col >= 5 && col <= 8) return tile_code_t'(4'(col + 7));
    if ((row % 2) == 1 && row != h / 2) return T_PELLET;
    return T_EMPTY;
  endfunction

endpackage

// File: rtl/maze_tile_pixel.sv
// rtl/maze_tile_pixel.sv - combinational tile pixel decoder: (code, ox, oy, blink) -> hit, colour
module maze_tile_pixel
  import maze_pkg::*;
#(
  parameter int TILE_BITS = 3
) (
  input  tile_code_t             i_code,
  input  logic [TILE_BITS-1:0]   i_ox,
  input  logic [TILE_BITS-1:0]   i_oy,
  input  logic                   i_blink,
  output logic                   o_hit,
  output logic [11:0]            o_rgb
);

  localparam int T = 1 << TILE_BITS;
  localparam logic [TILE_BITS-1:0] LO  = TILE_BITS'(T / 2 - 1);
  localparam logic [TILE_BITS-1:0] MID = TILE_BITS'(T / 2);
  localparam logic [TILE_BITS-1:0] HI  = TILE_BITS'(T / 2 + 1);
  localparam logic [TILE_BITS-1:0] Q1  = TILE_BITS'(T / 4);
  localparam logic [TILE_BITS-1:0] Q3  = TILE_BITS'(3 * T / 4 - 1);

  always_comb begin
    o_hit = 1'b0;
    o_rgb = COL_WALL;
    case (i_code)
      T_UP:     o_hit = (i_oy == HI);
      T_RIGHT:  o_hit = (i_ox == LO);
      T_DOWN:   o_hit = (i_oy == LO);
      T_LEFT:   o_hit = (i_ox == HI);
      T_UL:     o_hit = (i_oy == HI && i_ox >= HI) || (i_oy >= HI && i_ox == HI);
      T_UR:     o_hit = (i_oy == HI && i_ox <= LO) || (i_oy >= HI && i_ox == LO);
      T_LR:     o_hit = (i_oy == LO && i_ox <= LO) || (i_oy <= LO && i_ox == LO);
      T_LL:     o_hit = (i_oy == LO && i_ox >= HI) || (i_oy <= LO && i_ox == HI);
      T_PELLET: begin
        o_rgb = COL_PELLET;
        o_hit = (i_ox == LO || i_ox == MID) && (i_oy == LO || i_oy == MID);
      end
      T_POWER: begin
        o_rgb = COL_PELLET;
        o_hit = i_blink && (i_ox >= Q1) && (i_ox <= Q3) && (i_oy >= Q1) && (i_oy <= Q3);
      end
      T_DOOR: begin
        o_rgb = COL_DOOR;
        o_hit = (i_oy == HI);
      end
      default: o_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/maze_tile_renderer.sv
// rtl/maze_tile_renderer.sv - maze layer renderer with writable tile map and pellet bookkeeping
module maze_tile_renderer
  import maze_pkg::*;
#(
  parameter int TILE_BITS  = 3,
  parameter int MAP_W      = 28,
  parameter int MAP_H      = 31,
  parameter int BLINK_BITS = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_sx,
  input  logic [9:0] i_sy,
  input  logic       i_de,
  input  logic       i_frame_start,
  input  logic       i_reload,
  input  logic       i_eat_valid,
  input  logic [4:0] i_eat_col,
  input  logic [4:0] i_eat_row,
  output logic       o_eat_ready,
  output logic       o_ate_pellet,
  output logic       o_ate_power,
  output logic [8:0] o_pellets_left,
  output logic       o_busy,
  output logic [3:0] o_r,
  output logic [3:0] o_g,
  output logic [3:0] o_b,
  output logic       o_de_out
);

  localparam int CELLS = MAP_W * MAP_H;
  localparam int AW    = $clog2(CELLS);
  localparam int PW    = 10 - TILE_BITS;
  localparam int BW    = BLINK_BITS + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);
  localparam logic [PW-1:0] COLS      = PW'(MAP_W);
  localparam logic [PW-1:0] ROWS      = PW'(MAP_H);
  localparam logic [PW-1:0] LAST_COL  = PW'(MAP_W - 1);

  logic [3:0]           r_ram [CELLS];
  state_t               r_state, w_next;
  logic [AW-1:0]        r_ld_addr, r_eat_addr, r_s1_addr, w_rd_addr, w_eat_addr, w_waddr;
  logic [PW-1:0]        r_ld_col, r_ld_row, w_col, w_row;
  logic [8:0]           r_pellets;
  logic [BW-1:0]        r_blink;
  logic [3:0]           r_b_code, r_s2_code, w_wdata;
  logic [TILE_BITS-1:0] r_s1_ox, r_s1_oy, r_s2_ox, r_s2_oy;
  logic                 r_s1_vis, r_s1_de, r_s2_vis, r_s2_de, r_de_out;
  logic                 r_ate_pellet, r_ate_power, w_we, w_in_map, w_eat_in_map, w_hit;
  logic [11:0]          r_rgb, w_pix_rgb;
  tile_code_t           w_rom_code;

  assign w_col        = i_sx[9:TILE_BITS];
  assign w_row        = i_sy[9:TILE_BITS];
  assign w_in_map     = (w_col < COLS) && (w_row < ROWS);
  assign w_rd_addr    = w_in_map ? AW'(w_row) * AW'(MAP_W) + AW'(w_col) : '0;
  assign w_eat_in_map = ({1'b0, i_eat_col} < 6'(MAP_W)) && ({1'b0, i_eat_row} < 6'(MAP_H));
  assign w_eat_addr   = AW'(i_eat_row) * AW'(MAP_W) + AW'(i_eat_col);
  assign w_rom_code   = rom_tile(int'(r_ld_col), int'(r_ld_row), MAP_W, MAP_H);

  // Port A (render) and port B (FSM) share the array; reads see pre-write data.
  always_ff @(posedge i_clk) begin
    if (w_we) r_ram[w_waddr] <= w_wdata;
    r_b_code  <= r_ram[r_eat_addr];
    r_s2_code <= r_ram[r_s1_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_addr <= '0; r_s1_ox <= '0; r_s1_oy <= '0; r_s1_vis <= 1'b0; r_s1_de <= 1'b0;
      r_s2_ox   <= '0; r_s2_oy <= '0; r_s2_vis <= 1'b0; r_s2_de <= 1'b0;
      r_rgb     <= COL_BLACK; r_de_out <= 1'b0;
    end else begin
      r_s1_addr <= w_rd_addr;
      r_s1_ox   <= i_sx[TILE_BITS-1:0];
      r_s1_oy   <= i_sy[TILE_BITS-1:0];
      r_s1_vis  <= i_de && w_in_map;
      r_s1_de   <= i_de;
      r_s2_ox   <= r_s1_ox;
      r_s2_oy   <= r_s1_oy;
      r_s2_vis  <= r_s1_vis;
      r_s2_de   <= r_s1_de;
      r_rgb     <= (r_s2_vis && !o_busy && w_hit) ? w_pix_rgb : COL_BLACK;
      r_de_out  <= r_s2_de;
    end
  end

  maze_tile_pixel #(.TILE_BITS(TILE_BITS)) u_pixel (
    .i_code  (tile_code_t'(r_s2_code)),
    .i_ox    (r_s2_ox),
    .i_oy    (r_s2_oy),
    .i_blink (r_blink[BLINK_BITS]),
    .o_hit   (w_hit),
    .o_rgb   (w_pix_rgb)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_RELOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_reload) begin
      w_next = ST_RELOAD;
    end else begin
      case (r_state)
        ST_RELOAD: if (r_ld_addr == LAST_ADDR) w_next = ST_IDLE;
        ST_IDLE:   if (i_eat_valid && w_eat_in_map) w_next = ST_RD;
        ST_RD:     w_next = ST_CHK;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_eat_ready = 1'b0;
    o_busy      = 1'b0;
    w_we        = 1'b0;
    w_waddr     = r_eat_addr;
    w_wdata     = 4'd0;
    case (r_state)
      ST_RELOAD: begin
        o_busy  = 1'b1;
        w_we    = 1'b1;
        w_waddr = r_ld_addr;
        w_wdata = w_rom_code;
      end
      ST_IDLE: o_eat_ready = 1'b1;
      ST_CHK:  w_we = !i_reload && is_edible(tile_code_t'(r_b_code));
      default: w_we = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ld_addr <= '0; r_ld_col <= '0; r_ld_row <= '0; r_eat_addr <= '0;
      r_pellets <= '0; r_blink <= '0; r_ate_pellet <= 1'b0; r_ate_power <= 1'b0;
    end else begin
      r_ate_pellet <= 1'b0;
      r_ate_power  <= 1'b0;
      if (i_frame_start) r_blink <= r_blink + BW'(1);
      if (i_reload) begin
        r_ld_addr <= '0; r_ld_col <= '0; r_ld_row <= '0; r_pellets <= '0;
      end else begin
        case (r_state)
          ST_RELOAD: begin
            r_ld_addr <= r_ld_addr + AW'(1);
            if (r_ld_col == LAST_COL) begin
              r_ld_col <= '0;
              r_ld_row <= r_ld_row + PW'(1);
            end else begin
              r_ld_col <= r_ld_col + PW'(1);
            end
            r_pellets <= r_pellets + 9'(is_edible(w_rom_code));
          end
          ST_IDLE: if (i_eat_valid && w_eat_in_map) r_eat_addr <= w_eat_addr;
          ST_CHK: if (is_edible(tile_code_t'(r_b_code))) begin
            r_ate_pellet <= (r_b_code == T_PELLET);
            r_ate_power  <= (r_b_code == T_POWER);
            if (r_pellets != '0) r_pellets <= r_pellets - 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_pellets_left = r_pellets;
  assign o_ate_pellet   = r_ate_pellet;
  assign o_ate_power    = r_ate_power;
  assign {o_r, o_g, o_b} = r_rgb;
  assign o_de_out       = r_de_out;

endmodule
